// File: rtl/lcd_fb_writer.sv
// Packs the PPU's 2-bit pixel stream into bytes and writes them into a double-buffered framebuffer.
// Define LCD_FB_ERR_EN to build the line_err / err_count geometry-error tracking.
module lcd_fb_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_vsync,
  input  logic        lcd_hsync,
  input  logic        lcd_pixel,
  input  logic [1:0]  lcd_color,
  output logic [13:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_we,
  output logic        frame_done,
  output logic        disp_bank,
  output logic        line_err,
  output logic [7:0]  err_count
);

  typedef enum logic {WAIT_VSYNC, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d, y_q, y_d, pack_q, pack_d;
  logic        vsync_q, hsync_q;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        we_q, we_d, done_q, done_d, bank_q, bank_d;
  logic        vs_rise, hs_rise;
  logic [7:0]  pix_pack;
  logic [12:0] line_base;
  logic [1:0]  err_n;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    pack_d    = pack_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    bank_d    = bank_q;
    err_n     = 2'd0;
    pix_pack  = pack_q;
    vs_rise   = lcd_vsync & ~vsync_q;
    hs_rise   = lcd_hsync & ~hsync_q;
    line_base = {5'b0, y_q} * 13'd40;

    case (state_q)
      WAIT_VSYNC: begin
        if (vs_rise) begin
          state_d = ACTIVE;
          x_d     = 8'd0;
          y_d     = 8'd0;
          pack_d  = 8'd0;
        end
      end
      default: begin
        // The pixel of this cycle belongs to the old line/frame, so it goes first.
        if (lcd_pixel) begin
          if (x_q < 8'd160 && y_q < 8'd144) begin
            case (x_q[1:0])
              2'd0:    pix_pack = {lcd_color, 6'b0};
              2'd1:    pix_pack[5:4] = lcd_color;
              2'd2:    pix_pack[3:2] = lcd_color;
              default: pix_pack[1:0] = lcd_color;
            endcase
            pack_d = pix_pack;
            if (x_q[1:0] == 2'd3) begin
              we_d   = 1'b1;
              data_d = pix_pack;
              addr_d = {~bank_q, line_base + {7'b0, x_q[7:2]}};
              pack_d = 8'd0;
            end
            x_d = x_q + 8'd1;
          end else begin
            err_n = err_n + 2'd1;
          end
        end
        // A flush needs x%4!=0, so it never collides with a just-completed byte.
        if (hs_rise && x_d != 8'd0) begin
          if (x_d[1:0] != 2'd0) begin
            we_d   = 1'b1;
            data_d = pack_d;
            addr_d = {~bank_q, line_base + {7'b0, x_d[7:2]}};
          end
          if (x_d != 8'd160) err_n = err_n + 2'd1;
          x_d    = 8'd0;
          pack_d = 8'd0;
          y_d    = (y_q == 8'd144) ? y_q : y_q + 8'd1;
        end
        if (vs_rise) begin
          done_d = 1'b1;
          bank_d = ~bank_q;
          if (y_d != 8'd144) err_n = err_n + 2'd1;
          x_d    = 8'd0;
          y_d    = 8'd0;
          pack_d = 8'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= WAIT_VSYNC;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      pack_q  <= 8'd0;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      addr_q  <= 14'd0;
      data_q  <= 8'd0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pack_q  <= pack_d;
      vsync_q <= lcd_vsync;
      hsync_q <= lcd_hsync;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      bank_q  <= bank_d;
    end
  end

`ifdef LCD_FB_ERR_EN
  logic [7:0] err_q;
  logic       lerr_q;
  logic [8:0] err_sum;

  assign err_sum = {1'b0, err_q} + {7'b0, err_n};

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q  <= 8'd0;
      lerr_q <= 1'b0;
    end else begin
      err_q  <= err_sum[8] ? 8'hFF : err_sum[7:0];
      lerr_q <= lerr_q | (err_n != 2'd0);
    end
  end

  assign line_err  = lerr_q;
  assign err_count = err_q;
`else
  logic unused_err;
  assign unused_err = ^err_n;
  assign line_err   = 1'b0;
  assign err_count  = 8'd0;
`endif

  assign fb_addr    = addr_q;
  assign fb_data    = data_q;
  assign fb_we      = we_q;
  assign frame_done = done_q;
  assign disp_bank  = bank_q;

endmodule

// File: tb/tb_lcd_fb_writer.sv
// Bench for lcd_fb_writer: table-driven first line, full frame, geometry corners, reset mid-line.
// Error-count expectations follow LCD_FB_ERR_EN.
module tb_lcd_fb_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lcd_vsync = 1'b0, lcd_hsync = 1'b0, lcd_pixel = 1'b0;
  logic [1:0]  lcd_color = 2'd0;
  logic [13:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we, frame_done, disp_bank, line_err;
  logic [7:0]  err_count;

  lcd_fb_writer dut (
    .clk(clk), .rst(rst), .lcd_vsync(lcd_vsync), .lcd_hsync(lcd_hsync),
    .lcd_pixel(lcd_pixel), .lcd_color(lcd_color), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_we(fb_we), .frame_done(frame_done),
    .disp_bank(disp_bank), .line_err(line_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  data;
    int          due;
  } wr_t;

  typedef struct {
    logic [1:0] c [4];
    logic [7:0] data;
  } vec_t;

  wr_t         q[$];
  vec_t        tbl [8];
  int          checks = 0, errors = 0;
  int          cyc = 0, writes = 0, frames = 0;
  logic [13:0] last_addr = 14'd0;

  // Reference state of the frame being written
  bit          m_active = 0;
  bit          m_bank = 0;
  int          m_x = 0, m_y = 0, m_err = 0;
  logic [7:0]  m_pack = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (frame_done) frames++;
    if (fb_we) begin
      writes++;
      last_addr = fb_addr;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h at cycle %0d, none expected", fb_addr, fb_data, cyc);
      end else begin
        wr_t e;
        e = q.pop_front();
        checks++;
        if (fb_addr !== e.addr || fb_data !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h cycle=%0d expected addr=%h data=%h cycle=%0d",
                   fb_addr, fb_data, cyc, e.addr, e.data, e.due);
        end
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      wr_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_write: got no write expected addr=%h data=%h at cycle %0d", e.addr, e.data, e.due);
    end
  end

  task automatic drive(input logic v, input logic h, input logic p, input logic [1:0] c);
    lcd_vsync = v; lcd_hsync = h; lcd_pixel = p; lcd_color = c;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [7:0] d);
    wr_t e;
    e.addr = {~m_bank, 13'(idx)};
    e.data = d;
    e.due  = cyc + 1;
    q.push_back(e);
  endtask

  task automatic mpix(input logic [1:0] c);
    if (!m_active) return;
    if (m_x < 160 && m_y < 144) begin
      m_pack[6 - 2 * (m_x % 4) +: 2] = c;
      if (m_x % 4 == 3) begin
        push(m_y * 40 + m_x / 4, m_pack);
        m_pack = 8'd0;
      end
      m_x++;
    end else begin
      m_err++;
    end
  endtask

  task automatic pix(input logic [1:0] c);
    mpix(c);
    drive(1'b0, 1'b0, 1'b1, c);
  endtask

  task automatic hsync();
    if (m_active && m_x != 0) begin
      if (m_x % 4 != 0) push(m_y * 40 + m_x / 4, m_pack);
      if (m_x != 160) m_err++;
      m_x = 0;
      m_pack = 8'd0;
      if (m_y < 144) m_y++;
    end
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    drive(1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic vsync(input logic p, input logic [1:0] c);
    bit was_active;
    was_active = m_active;
    if (p) mpix(c);
    if (was_active) begin
      if (m_y != 144) m_err++;
      m_bank = ~m_bank;
    end
    m_active = 1;
    m_x = 0; m_y = 0; m_pack = 8'd0;
    drive(1'b1, 1'b0, p, c);
    chk("frame_done_pulse", frame_done, was_active);
    chk("disp_bank_after_vsync", disp_bank, m_bank);
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    chk("frame_done_one_cycle", frame_done, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    m_active = 0; m_bank = 0; m_err = 0; m_x = 0; m_y = 0; m_pack = 8'd0;
  endtask

  function automatic logic [7:0] exp_cnt();
`ifdef LCD_FB_ERR_EN
    return (m_err > 255) ? 8'hFF : 8'(m_err);
`else
    return 8'd0;
`endif
  endfunction

  function automatic logic exp_lerr();
`ifdef LCD_FB_ERR_EN
    return m_err != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_err(input string name);
    chk({name, "_err_count"}, err_count, exp_cnt());
    chk({name, "_line_err"}, line_err, exp_lerr());
  endtask

  initial begin
    tbl[0] = '{'{2'd0, 2'd1, 2'd2, 2'd3}, 8'h1B};
    tbl[1] = '{'{2'd1, 2'd1, 2'd1, 2'd1}, 8'h55};
    tbl[2] = '{'{2'd3, 2'd3, 2'd3, 2'd3}, 8'hFF};
    tbl[3] = '{'{2'd0, 2'd0, 2'd0, 2'd0}, 8'h00};
    tbl[4] = '{'{2'd3, 2'd2, 2'd1, 2'd0}, 8'hE4};
    tbl[5] = '{'{2'd2, 2'd2, 2'd2, 2'd2}, 8'hAA};
    tbl[6] = '{'{2'd1, 2'd0, 2'd0, 2'd0}, 8'h40};
    tbl[7] = '{'{2'd0, 2'd0, 2'd0, 2'd3}, 8'h03};

    #1;
    do_reset();
    chk("reset_fb_we", fb_we, 1'b0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_disp_bank", disp_bank, 1'b0);
    chk("reset_fb_addr", fb_addr, 14'd0);
    chk("reset_fb_data", fb_data, 8'd0);
    chk_err("reset");

    // Pixels and hsync before the first vsync are ignored
    repeat (8) pix(2'd3);
    hsync();
    chk_err("wait_vsync");

    // Frame 1: table-driven line 0, then 143 lines of shade 1
    vsync(1'b0, 2'd0);
    for (int g = 0; g < 40; g++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3) begin
          wr_t e;
          e.addr = 14'h2000 + 14'(g);
          e.data = tbl[g % 8].data;
          e.due  = cyc + 1;
          q.push_back(e);
        end
        drive(1'b0, 1'b0, 1'b1, tbl[g % 8].c[k]);
      end
    end
    m_x = 160;
    hsync();
    for (int ln = 1; ln < 144; ln++) begin
      repeat (160) pix(2'd1);
      hsync();
    end
    vsync(1'b0, 2'd0);
    chk("frame1_writes", writes, 5760);
    chk("frame1_last_addr", last_addr, 14'h367F);
    chk("frame1_frames", frames, 1);
    chk("frame1_bank", disp_bank, 1'b1);
    chk_err("frame1");

    // Frame 2 (writes bank 0): overlong line, short line with flush, ignored hsync
    repeat (162) pix(2'd2);
    hsync();
    chk_err("overlong_line");
    repeat (6) pix(2'd3);
    hsync();
    chk_err("short_line");
    repeat (4) pix(2'd1);
    hsync();
    hsync();
    chk_err("hsync_at_x0");
    repeat (4) pix(2'd2);
    hsync();
    pix(2'd1); pix(2'd2); pix(2'd3);
    vsync(1'b1, 2'd0);
    chk("frame2_frames", frames, 2);
    chk_err("early_vsync");

    // Frame 3: reset mid-line discards the partial byte and needs a fresh vsync
    repeat (5) pix(2'd1);
    do_reset();
    chk("midreset_disp_bank", disp_bank, 1'b0);
    chk("midreset_fb_we", fb_we, 1'b0);
    chk_err("midreset");
    repeat (8) pix(2'd1);
    hsync();
    vsync(1'b0, 2'd0);
    repeat (4) pix(2'd2);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 2'd0);
    chk("final_last_addr", last_addr, 14'h2000);
    chk("scoreboard_drained", q.size(), 0);
    chk("total_frames", frames, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
